// File: rtl/seq_det_scheduler_pkg.sv
// Shared types and constants for the "011" detector scheduler slice.
package seq_det_scheduler_pkg;

    // Engine state encoding; S3 is the "011 just seen" state.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } eng_state_t;

    // Scheduler frame-level states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_STREAM,
        ST_FLUSH,
        ST_REPORT
    } sched_state_t;

    // Length of the detected pattern "011".
    localparam int unsigned PAT_LEN = 3;

endpackage

// File: rtl/seq_det_scheduler_core.sv
// Moore "011" detector engine; advances only on en, clr returns it to S0.
module seq_det_core
    import seq_det_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic out
);

    eng_state_t state;
    eng_state_t state_next;

    // Engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear wins, otherwise hold unless a bit is accepted.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = S0;
        end else if (en) begin
            unique case (state)
                S0:      state_next = x ? S0 : S1;
                S1:      state_next = x ? S2 : S1;
                S2:      state_next = x ? S3 : S1;
                S3:      state_next = x ? S0 : S1;
                default: state_next = S0;
            endcase
        end
    end

    assign out = (state == S3);

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one "011" detector between N_CH bit streams.
module seq_det_scheduler
    import seq_det_scheduler_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         bit_valid,
    input  logic [N_CH-1:0]         bit_data,
    input  logic [N_CH-1:0]         bit_last,
    output logic [N_CH-1:0]         bit_ready,
    output logic [N_CH-1:0]         grant,
    output logic                    res_valid,
    output logic [$clog2(N_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]        res_count,
    output logic                    res_hit,
    input  logic                    res_ready
);

    localparam int unsigned CH_W = $clog2(N_CH);

    sched_state_t    state;
    sched_state_t    state_next;
    logic [CH_W-1:0] owner;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] cand;
    logic            pick_found;
    logic            accept;
    logic            last_accept;
    logic            handshake;
    logic            engine_clr;
    logic            engine_out;
    logic            fresh;
    logic            bump;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign accept      = (state == ST_STREAM) && bit_valid[owner];
    assign last_accept = accept && bit_last[owner];
    assign handshake   = (state == ST_REPORT) && res_ready;
    assign res_valid   = (state == ST_REPORT);
    assign engine_clr  = (state == ST_ARB);

    // A detection counts once: only in the cycle right after the bit that produced it.
    assign bump       = fresh && engine_out && (count != '1)
                        && ((state == ST_STREAM) || (state == ST_FLUSH));
    assign count_next = bump ? count + CNT_W'(1) : count;

    seq_det_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (engine_clr),
        .en    (accept),
        .x     (bit_data[owner]),
        .out   (engine_out)
    );

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = CH_W'((32'(rr_ptr) + i) % N_CH);
            if (!pick_found && req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Ready is offered only to the owner while streaming.
    always_comb begin
        bit_ready = '0;
        if (state == ST_STREAM) begin
            bit_ready[owner] = 1'b1;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (|req) state_next = ST_ARB;
            ST_ARB:    state_next = pick_found ? ST_STREAM : ST_IDLE;
            ST_STREAM: if (last_accept) state_next = ST_FLUSH;
            ST_FLUSH:  state_next = ST_REPORT;
            ST_REPORT: if (handshake) state_next = (|req) ? ST_ARB : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Ownership, grant and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= '0;
            grant  <= '0;
            rr_ptr <= '0;
        end else if ((state == ST_ARB) && pick_found) begin
            owner <= pick;
            grant <= {{(N_CH-1){1'b0}}, 1'b1} << pick;
        end else if (handshake) begin
            grant  <= '0;
            rr_ptr <= (owner == CH_W'(N_CH - 1)) ? '0 : owner + CH_W'(1);
        end
    end

    // Per-frame detection counter and accepted-bit marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            fresh <= 1'b0;
        end else if (state == ST_ARB) begin
            count <= '0;
            fresh <= 1'b0;
        end else begin
            count <= count_next;
            fresh <= accept;
        end
    end

    // Result capture in FLUSH includes the detection caused by the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_ch    <= '0;
            res_count <= '0;
            res_hit   <= 1'b0;
        end else if (state == ST_FLUSH) begin
            res_ch    <= owner;
            res_count <= count_next;
            res_hit   <= (count_next != '0);
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Randomised bench for seq_det_scheduler against a frame-level reference model.
module tb_seq_det_scheduler;
    import seq_det_scheduler_pkg::*;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned MAX_LEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] req, bit_valid, bit_data, bit_last;
    logic [N_CH-1:0] bit_ready, grant, bit_ready_s, grant_s;
    logic            res_valid, res_valid_s, res_hit, res_hit_s, res_ready;
    logic [CH_W-1:0] res_ch, res_ch_s;
    logic [CNT_W-1:0] res_count;
    logic [1:0]      res_count_s;

    always #5 clk = ~clk;

    seq_det_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_last(bit_last), .bit_ready(bit_ready), .grant(grant), .res_valid(res_valid),
        .res_ch(res_ch), .res_count(res_count), .res_hit(res_hit), .res_ready(res_ready)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    seq_det_scheduler #(.N_CH(N_CH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_last(bit_last), .bit_ready(bit_ready_s), .grant(grant_s), .res_valid(res_valid_s),
        .res_ch(res_ch_s), .res_count(res_count_s), .res_hit(res_hit_s), .res_ready(res_ready)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    int unsigned frm_len [N_CH];
    logic        frm_bits[N_CH][MAX_LEN];
    int unsigned pos      [N_CH];
    int unsigned wait_left[N_CH];
    bit          pending  [N_CH];

    int          gap_cfg;
    int unsigned res_mode;
    bit          gen_en;
    int unsigned rr_model, owner, exp_cnt, cyc, last_acc_cyc, rv_wait;
    bit          owner_valid, streaming, awaiting, rv_prev;
    logic [N_CH-1:0] grant_prev;
    logic [CH_W-1:0] cap_ch;
    logic [CNT_W-1:0] cap_cnt;
    logic            cap_hit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Overlapping occurrences of 011 in the frame, by sliding window.
    function automatic int unsigned pattern_hits(input int unsigned ch);
        int unsigned n = 0;
        for (int unsigned k = PAT_LEN - 1; k < frm_len[ch]; k++)
            if ({frm_bits[ch][k-2], frm_bits[ch][k-1], frm_bits[ch][k]} == 3'b011) n++;
        return n;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned w);
        int unsigned mx = (32'd1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic bit busy();
        bit b = owner_valid || awaiting || (req != '0);
        for (int unsigned i = 0; i < N_CH; i++) b = b || pending[i];
        return b;
    endfunction

    // rnd: 0 = bits from pat (MSB first), 1 = random, 2 = repeated 011 groups
    task automatic load_frame(input int unsigned ch, input int unsigned len,
                              input logic [31:0] pat, input int unsigned rnd);
        frm_len[ch] = len;
        for (int unsigned k = 0; k < len; k++) begin
            case (rnd)
                0:       frm_bits[ch][k] = pat[len-1-k];
                1:       frm_bits[ch][k] = 1'($urandom_range(0, 1));
                default: frm_bits[ch][k] = (k % 3) != 0;
            endcase
        end
        pos[ch] = 0;
        wait_left[ch] = 0;
        pending[ch] = 1'b1;
        req[ch] = 1'b1;
    endtask

    task automatic step();
        int unsigned exp_ch;
        bit found;
        logic [N_CH-1:0] exp_grant, exp_ready;
        bit exp_rv;
        cyc++;
        // New grant: the model re-derives the round-robin choice from the req seen in ARB.
        if (grant_prev == '0 && grant != '0 && !owner_valid) begin
            found = 1'b0;
            exp_ch = 0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                int unsigned c;
                c = (rr_model + i) % N_CH;
                if (!found && req[c]) begin
                    found = 1'b1;
                    exp_ch = c;
                end
            end
            check_eq("arb_has_requester", 32'(found), 1);
            owner = exp_ch;
            owner_valid = 1'b1;
            streaming = 1'b1;
            exp_cnt = pattern_hits(exp_ch);
        end
        exp_grant = owner_valid ? (N_CH'(1) << owner) : '0;
        exp_ready = streaming ? exp_grant : '0;
        exp_rv = awaiting && (cyc >= last_acc_cyc + 2);
        check_eq("grant", grant, exp_grant);
        check_eq("grant_sat", grant_s, exp_grant);
        check_eq("bit_ready", bit_ready, exp_ready);
        check_eq("res_valid", res_valid, exp_rv);
        check_eq("res_valid_sat", res_valid_s, exp_rv);
        if (res_valid && !rv_prev) begin
            check_eq("res_ch", res_ch, owner);
            check_eq("res_count", res_count, sat(exp_cnt, CNT_W));
            check_eq("res_hit", res_hit, exp_cnt != 0);
            check_eq("res_count_sat", res_count_s, sat(exp_cnt, 2));
            check_eq("res_hit_sat", res_hit_s, exp_cnt != 0);
            cap_ch = res_ch;
            cap_cnt = res_count;
            cap_hit = res_hit;
            rv_wait = 0;
        end else if (res_valid) begin
            check_eq("res_hold", {res_ch, res_count, res_hit}, {cap_ch, cap_cnt, cap_hit});
        end
        for (int unsigned i = 0; i < N_CH; i++)
            if (grant[i]) req[i] = 1'b0;
        case (res_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = $urandom_range(0, 2) != 0;
            default: res_ready = rv_wait >= 5;
        endcase
        if (res_valid) rv_wait++;
        if (res_valid && res_ready) begin
            rr_model = (owner + 1) % N_CH;
            owner_valid = 1'b0;
            awaiting = 1'b0;
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (pending[i] && wait_left[i] == 0) begin
                bit_valid[i] = 1'b1;
                bit_data[i]  = frm_bits[i][pos[i]];
                bit_last[i]  = (pos[i] == frm_len[i] - 1);
            end else begin
                if (pending[i]) wait_left[i]--;
                bit_valid[i] = pending[i] ? 1'b0 : 1'($urandom_range(0, 1));
                bit_data[i]  = 1'($urandom_range(0, 1));
                bit_last[i]  = 1'($urandom_range(0, 1));
            end
            if (pending[i] && bit_valid[i] && bit_ready[i]) begin
                if (bit_last[i]) begin
                    pending[i] = 1'b0;
                    streaming = 1'b0;
                    awaiting = 1'b1;
                    last_acc_cyc = cyc;
                end else begin
                    pos[i]++;
                    wait_left[i] = (gap_cfg < 0) ? $urandom_range(0, 3) : gap_cfg;
                end
            end
        end
        if (gen_en) begin
            for (int unsigned i = 0; i < N_CH; i++)
                if (!pending[i] && !req[i] && !(owner_valid && owner == i)
                    && $urandom_range(0, 9) == 0)
                    load_frame(i, $urandom_range(1, 20), '0, $urandom_range(1, 2));
        end
        rv_prev = res_valid;
        grant_prev = grant;
    endtask

    task automatic cycle();
        @(negedge clk);
        step();
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", 32'(busy()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bit_ready"}, bit_ready, 0);
        check_eq({tag, "_grant"}, grant, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_ch"}, res_ch, 0);
        check_eq({tag, "_res_count"}, res_count, 0);
        check_eq({tag, "_res_hit"}, res_hit, 0);
    endtask

    task automatic clear_model();
        for (int unsigned i = 0; i < N_CH; i++) pending[i] = 1'b0;
        req = '0;
        bit_valid = '0;
        owner_valid = 1'b0;
        streaming = 1'b0;
        awaiting = 1'b0;
        rv_prev = 1'b0;
        rr_model = 0;
        grant_prev = '0;
    endtask

    initial begin
        int unsigned n;
        bit_data = '0;
        bit_last = '0;
        res_ready = 1'b0;
        rst_n = 1'b0;
        gen_en = 1'b0;
        gap_cfg = 0;
        res_mode = 0;
        cyc = 0;
        last_acc_cyc = 0;
        rv_wait = 0;
        owner = 0;
        exp_cnt = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single channel, one detection.
        load_frame(0, 3, 32'b011, 0);
        drain(100);
        // Overlapping detections, then the same frame with 3-cycle stalls.
        load_frame(2, 7, 32'b0110111, 0);
        drain(100);
        gap_cfg = 3;
        load_frame(2, 7, 32'b0110111, 0);
        drain(200);
        gap_cfg = 0;
        // Five 011 groups: saturates the 2-bit instance; leaves rr pointer at 0.
        load_frame(3, 15, 32'b011011011011011, 0);
        drain(200);
        // All four requesting with the result port stalled, two rounds.
        res_mode = 2;
        for (int unsigned i = 0; i < N_CH; i++) load_frame(i, $urandom_range(1, 20), '0, 1);
        drain(1000);
        for (int unsigned i = 0; i < N_CH; i++) load_frame(i, $urandom_range(1, 20), '0, 1);
        drain(1000);
        // Single-bit frame.
        res_mode = 0;
        load_frame(1, 1, 32'b1, 0);
        drain(100);
        // Random traffic with bubbles and result back-pressure.
        gap_cfg = -1;
        res_mode = 1;
        gen_en = 1'b1;
        repeat (3000) cycle();
        gen_en = 1'b0;
        drain(3000);

        // Reset in the middle of a frame on ch1.
        gap_cfg = 1;
        res_mode = 0;
        load_frame(1, 16, '0, 2);
        n = 0;
        while (pos[1] < 4 && n < 200) begin
            cycle();
            n++;
        end
        check_eq("abort_point_reached", 32'(pos[1] >= 4), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        gap_cfg = 0;
        load_frame(1, 5, 32'b01101, 0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
